// File: rtl/tile_pkg.sv
// ---------------------------------------------------------------------------
// tile_pkg
// Shared constants for the tile pixel renderer:
//   - tile geometry (TILE_SHIFT, MAP_COLS, MAP_ROWS, MAP_SIZE)
//   - pipeline latency in pixel ticks (PIPE_DEPTH)
//   - tile type codes (TILE_FLOOR .. TILE_BOMB)
//   - 16-entry 12-bit {R,G,B} palette table
// ---------------------------------------------------------------------------
package tile_pkg;

    localparam int TILE_SHIFT = 5;
    localparam int MAP_COLS   = 20;
    localparam int MAP_ROWS   = 15;
    localparam int MAP_SIZE   = MAP_COLS * MAP_ROWS;
    localparam int PIPE_DEPTH = 3;

    localparam logic [1:0] TILE_FLOOR = 2'd0;
    localparam logic [1:0] TILE_WALL  = 2'd1;
    localparam logic [1:0] TILE_BRICK = 2'd2;
    localparam logic [1:0] TILE_BOMB  = 2'd3;

    // Index 0 is unused by the sprites and kept black.
    localparam logic [11:0] PALETTE [16] = '{
        12'h000, 12'h0A0, 12'h888, 12'h444,
        12'hB52, 12'h999, 12'h112, 12'hF00,
        12'h0F0, 12'h00F, 12'hFF0, 12'h0FF,
        12'hF0F, 12'hFFF, 12'h555, 12'hAAA
    };

endpackage

// File: rtl/tile_pixel_renderer_if.sv
// ---------------------------------------------------------------------------
// tile_pixel_renderer_if
// Pixel-stream and map-write bundle between the sync generator / game logic
// (master) and the tile pixel renderer (slave).
//   p_tick, x_pos, y_pos, display_on, hsync_in, vsync_in : pixel stream in
//   map_wr_en, map_wr_addr, map_wr_data                   : tile map writes
//   rgb, hsync, vsync                                     : VGA outputs
// Flow: there is no back-pressure. A pixel is transferred on every clk edge
// where p_tick is 1; map writes take effect on every edge where map_wr_en is 1.
// ---------------------------------------------------------------------------
interface tile_pixel_renderer_if;

    logic        p_tick;
    logic [9:0]  x_pos;
    logic [9:0]  y_pos;
    logic        display_on;
    logic        hsync_in;
    logic        vsync_in;
    logic        map_wr_en;
    logic [8:0]  map_wr_addr;
    logic [1:0]  map_wr_data;
    logic [11:0] rgb;
    logic        hsync;
    logic        vsync;

    modport master (
        output p_tick, x_pos, y_pos, display_on, hsync_in, vsync_in,
        output map_wr_en, map_wr_addr, map_wr_data,
        input  rgb, hsync, vsync
    );

    modport slave (
        input  p_tick, x_pos, y_pos, display_on, hsync_in, vsync_in,
        input  map_wr_en, map_wr_addr, map_wr_data,
        output rgb, hsync, vsync
    );

endinterface

// File: rtl/tile_map_ram.sv
// ---------------------------------------------------------------------------
// tile_map_ram
// 300 x 2-bit tile map, one write port and one registered read port.
//   clk      : clock
//   wr_en    : write strobe (addresses >= 300 are ignored)
//   wr_addr  : write tile index
//   wr_data  : tile type
//   rd_en    : read enable; rd_data holds while low
//   rd_addr  : read tile index (>= 300 reads back 0)
//   rd_data  : registered read data
// Same-address write and read on one edge return the old contents.
// Contents are not reset; game logic initialises the map.
// ---------------------------------------------------------------------------
module tile_map_ram
    import tile_pkg::*;
(
    input  logic       clk,
    input  logic       wr_en,
    input  logic [8:0] wr_addr,
    input  logic [1:0] wr_data,
    input  logic       rd_en,
    input  logic [8:0] rd_addr,
    output logic [1:0] rd_data
);

    logic [1:0] mem [0:MAP_SIZE-1];

    always_ff @(posedge clk) begin
        if (wr_en && (wr_addr < 9'(MAP_SIZE))) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Non-blocking read of mem gives read-before-write on a collision.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            if (rd_addr < 9'(MAP_SIZE)) begin
                rd_data <= mem[rd_addr];
            end else begin
                rd_data <= 2'b00;
            end
        end
    end

endmodule

// File: rtl/tile_pixel_renderer.sv
// ---------------------------------------------------------------------------
// tile_pixel_renderer
// Converts the sync generator's pixel position into 12-bit RGB from a 20x15
// map of 32x32 tiles, through a 3-stage pixel-tick pipeline:
//   S1 map read, S2 sprite lookup, S3 palette + blanking.
// hsync/vsync are delayed through the same three stages.
//   clk : 100 MHz clock
//   rst : synchronous reset, active low
//   bus : tile_pixel_renderer_if.slave (pixel stream, map writes, VGA out)
// Optional build macro GRID_OVERLAY_EN: visible pixels on tile column 0 or
// tile row 0 are forced black, drawing a grid.
// ---------------------------------------------------------------------------
module tile_pixel_renderer
    import tile_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    tile_pixel_renderer_if.slave  bus
);

    // -------------------- S1: map read --------------------
    logic [8:0] rd_addr;
    logic [1:0] s1_tile;
    logic [4:0] s1_x;
    logic [4:0] s1_y;
    logic       s1_disp;
    logic       s1_hs;
    logic       s1_vs;

    // 9-bit arithmetic; out-of-screen positions only occur while blanked.
    assign rd_addr = {4'b0000, bus.y_pos[9:TILE_SHIFT]} * 9'(MAP_COLS)
                   + {4'b0000, bus.x_pos[9:TILE_SHIFT]};

    tile_map_ram u_map (
        .clk     (clk),
        .wr_en   (bus.map_wr_en),
        .wr_addr (bus.map_wr_addr),
        .wr_data (bus.map_wr_data),
        .rd_en   (bus.p_tick),
        .rd_addr (rd_addr),
        .rd_data (s1_tile)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_x    <= '0;
            s1_y    <= '0;
            s1_disp <= 1'b0;
            s1_hs   <= 1'b0;
            s1_vs   <= 1'b0;
        end else if (bus.p_tick) begin
            s1_x    <= bus.x_pos[4:0];
            s1_y    <= bus.y_pos[4:0];
            s1_disp <= bus.display_on;
            s1_hs   <= bus.hsync_in;
            s1_vs   <= bus.vsync_in;
        end
    end

    // -------------------- S2: sprite lookup --------------------
    function automatic logic [3:0] sprite_index(
        input logic [1:0] tile,
        input logic [4:0] x,
        input logic [4:0] y
    );
        logic [4:0]  ax;
        logic [4:0]  ay;
        logic [10:0] dist2;
        logic [3:0]  idx;
        // Distances from the bomb centre (15,15); at most 16.
        ax    = (x >= 5'd15) ? (x - 5'd15) : (5'd15 - x);
        ay    = (y >= 5'd15) ? (y - 5'd15) : (5'd15 - y);
        dist2 = 11'(ax * ax) + 11'(ay * ay);
        idx   = 4'd1;
        case (tile)
            TILE_FLOOR: idx = 4'd1;
            TILE_WALL: begin
                if (x == 5'd0 || x == 5'd31 || y == 5'd0 || y == 5'd31)
                    idx = 4'd3;
                else
                    idx = 4'd2;
            end
            TILE_BRICK: begin
                // Horizontal mortar every 8 rows; vertical joints every 16
                // columns, shifted by 8 on alternating 8-row courses.
                if (y[2:0] == 3'd0 || x[3:0] == {y[3], 3'b000})
                    idx = 4'd5;
                else
                    idx = 4'd4;
            end
            TILE_BOMB: idx = (dist2 < 11'd144) ? 4'd6 : 4'd1;
            default: idx = 4'd1;
        endcase
        return idx;
    endfunction

    logic [3:0] s2_idx;
    logic       s2_disp;
    logic       s2_hs;
    logic       s2_vs;
`ifdef GRID_OVERLAY_EN
    logic       s2_grid;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            s2_idx  <= '0;
            s2_disp <= 1'b0;
            s2_hs   <= 1'b0;
            s2_vs   <= 1'b0;
        end else if (bus.p_tick) begin
            s2_idx  <= sprite_index(s1_tile, s1_x, s1_y);
            s2_disp <= s1_disp;
            s2_hs   <= s1_hs;
            s2_vs   <= s1_vs;
        end
    end

`ifdef GRID_OVERLAY_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            s2_grid <= 1'b0;
        end else if (bus.p_tick) begin
            s2_grid <= (s1_x == 5'd0) || (s1_y == 5'd0);
        end
    end
`endif

    // -------------------- S3: palette + blanking --------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.rgb   <= '0;
            bus.hsync <= 1'b0;
            bus.vsync <= 1'b0;
        end else if (bus.p_tick) begin
            bus.hsync <= s2_hs;
            bus.vsync <= s2_vs;
`ifdef GRID_OVERLAY_EN
            if (!s2_disp || s2_grid)
                bus.rgb <= 12'h000;
            else
                bus.rgb <= PALETTE[s2_idx];
`else
            if (!s2_disp)
                bus.rgb <= 12'h000;
            else
                bus.rgb <= PALETTE[s2_idx];
`endif
        end
    end

endmodule

// File: tb/tb_tile_pixel_renderer.sv
// ---------------------------------------------------------------------------
// tb_tile_pixel_renderer
// Drives a pixel stream and map writes into tile_pixel_renderer; a reference
// model computes each pixel's {hsync, vsync, rgb} at issue time and queues
// it, and a monitor compares the DUT output on every pixel tick.
// Honours GRID_OVERLAY_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_tile_pixel_renderer;

    localparam int W = 14;  // {hsync, vsync, rgb[11:0]}

    // -------------------- clock / reset --------------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    tile_pixel_renderer_if bus ();

    tile_pixel_renderer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // -------------------- reference model --------------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_exp = '0;
    int total = 0;
    int bad   = 0;
    int shadow[300];
    int phase = 0;

    logic [11:0] pal [16] = '{
        12'h000, 12'h0A0, 12'h888, 12'h444,
        12'hB52, 12'h999, 12'h112, 12'hF00,
        12'h0F0, 12'h00F, 12'hFF0, 12'h0FF,
        12'hF0F, 12'hFFF, 12'h555, 12'hAAA
    };

    function automatic int sprite(int t, int px, int py);
        case (t)
            0: return 1;
            1: return (px == 0 || px == 31 || py == 0 || py == 31) ? 3 : 2;
            2: return ((py % 8) == 0 || (px % 16) == ((py / 8) % 2) * 8) ? 5 : 4;
            default: return ((px - 15) * (px - 15) + (py - 15) * (py - 15) < 144) ? 6 : 1;
        endcase
    endfunction

    function automatic logic [W-1:0] model_px(int x, int y, bit hs, bit vs);
        logic [11:0] col;
        bit vis;
        vis = (x < 640) && (y < 480);
        col = 12'h000;
        if (vis) begin
            col = pal[sprite(shadow[(y / 32) * 20 + x / 32], x % 32, y % 32)];
`ifdef GRID_OVERLAY_EN
            if ((x % 32) == 0 || (y % 32) == 0) col = 12'h000;
`endif
        end
        return {hs, vs, col};
    endfunction

    // -------------------- scoreboard check --------------------
    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // -------------------- driver --------------------
    // Called at a negedge; applies one clk of stimulus and waits for the next
    // negedge. p_tick is 1 on every fourth clk.
    task automatic cycle(input bit we, input int wa, input int wd,
                         input int x, input int y, input bit hs, input bit vs);
        bit tick;
        tick = (phase == 3);
        phase = (phase + 1) % 4;
        bus.p_tick      = tick;
        bus.x_pos       = 10'(x);
        bus.y_pos       = 10'(y);
        bus.display_on  = (x < 640) && (y < 480);
        bus.hsync_in    = hs;
        bus.vsync_in    = vs;
        bus.map_wr_en   = we;
        bus.map_wr_addr = 9'(wa);
        bus.map_wr_data = 2'(wd);
        // Expected value uses the map before this edge's write lands.
        if (tick && rst) exp_q.push_back(model_px(x, y, hs, vs));
        if (we && wa < 300) shadow[wa] = wd;
        @(negedge clk);
    endtask

    task automatic tick_cycle(input bit we, input int wa, input int wd,
                              input int x, input int y, input bit hs, input bit vs);
        while (phase != 3) cycle(1'b0, 0, 0, 700, 500, 1'b0, 1'b0);
        cycle(we, wa, wd, x, y, hs, vs);
    endtask

    task automatic random_ticks(input int n, input bit with_writes);
        for (int i = 0; i < n * 4; i++) begin
            cycle(with_writes && ($urandom_range(0, 3) == 0),
                  $urandom_range(0, 319), $urandom_range(0, 3),
                  $urandom_range(0, 799), $urandom_range(0, 524),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic restart_pipe();
        exp_q.delete();
        exp_q.push_back('0);
        exp_q.push_back('0);
        last_exp = '0;
    endtask

    // -------------------- monitor --------------------
    always @(posedge clk) begin
        if (rst) begin
            if (bus.p_tick) begin
                #1;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pipe_out: no expected entry, got %h", {bus.hsync, bus.vsync, bus.rgb});
                end else begin
                    last_exp = exp_q.pop_front();
                    check("pipe_out", {bus.hsync, bus.vsync, bus.rgb}, last_exp);
                end
            end else begin
                #1;
                check("hold_between_ticks", {bus.hsync, bus.vsync, bus.rgb}, last_exp);
            end
        end
    end

    // -------------------- main sequence --------------------
    initial begin
        // Reset held 10 clk with pixel ticks running.
        for (int i = 0; i < 10; i++) cycle(1'b0, 0, 0, 100, 100, 1'b1, 1'b1);
        check("reset_rgb",   {2'b00, bus.rgb},          '0);
        check("reset_hsync", {13'd0, bus.hsync},        '0);
        check("reset_vsync", {13'd0, bus.vsync},        '0);

        restart_pipe();
        rst = 1'b1;

        // Initialise map to floor while the stream is in blanking.
        for (int a = 0; a < 300; a++) cycle(1'b1, a, 0, 700, 500, 1'b0, 1'b1);

        // All-floor frame sample.
        random_ticks(300, 1'b0);

        // Wall at (col 2,row 1): edges and interior.
        tick_cycle(1'b1, 22, 1, 700, 500, 1'b0, 1'b0);
        tick_cycle(1'b0, 0, 0, 64, 32, 1'b1, 1'b0);
        tick_cycle(1'b0, 0, 0, 95, 63, 1'b0, 1'b1);
        tick_cycle(1'b0, 0, 0, 70, 40, 1'b1, 1'b1);

        // Out-of-range write is ignored.
        tick_cycle(1'b1, 300, 3, 700, 500, 1'b0, 1'b0);
        tick_cycle(1'b0, 0, 0, 5, 5, 1'b0, 1'b0);
        random_ticks(100, 1'b0);

        // Write and S1 read of address 0 on the same clk: old (floor) shown.
        tick_cycle(1'b1, 0, 3, 15, 15, 1'b0, 1'b0);
        tick_cycle(1'b0, 0, 0, 15, 15, 1'b0, 1'b0);

        // Grid overlay pixel.
        tick_cycle(1'b0, 0, 0, 32, 100, 1'b0, 0);
        tick_cycle(1'b0, 0, 0, 33, 100, 1'b0, 0);

        // Random map contents, positions and syncs.
        random_ticks(1500, 1'b1);

        // Mid-frame reset: pipeline blanks at once.
        rst = 1'b0;
        for (int i = 0; i < 6; i++) cycle(1'b0, 0, 0, 200, 200, 1'b1, 1'b1);
        check("midreset_out", {bus.hsync, bus.vsync, bus.rgb}, '0);
        restart_pipe();
        rst = 1'b1;
        random_ticks(500, 1'b1);

        // Flush with blank pixels; two pipeline entries stay in flight.
        random_ticks(4, 1'b0);
        total++;
        if (exp_q.size() != 2) begin
            bad++;
            $display("FAIL queue_drain: entries left %0d expected 2", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
